// File: rtl/store_narrow_rmw.sv
// store_narrow_rmw: byte/half/word store with read-modify-write; STORE_NARROW_TRUNC_CHECK_EN adds trunc_err
module store_narrow_rmw #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              done,
    output logic              err,
`ifdef STORE_NARROW_TRUNC_CHECK_EN
    output logic              trunc_err,
`endif
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;
    logic [1:0]        state, ns;
    logic [ADDR_W-1:0] a_q;
    logic [31:0]       d_q, mask, rep;
    logic [1:0]        sz_q;
    logic              accept, bad;
    assign accept = req_valid && req_ready;
    assign bad = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    always_comb begin
        ns = state == IDLE ? (accept ? (bad ? RESP : (req_size == 2'b10 ? WR : RD)) : IDLE)
           : state == RD   ? WR
           : state == WR   ? RESP
           : IDLE;
    end
    // rdata arrives during WR, so the merge is formed combinationally from it there
    assign mask = sz_q == 2'b00 ? 32'hFF << {a_q[1:0], 3'b000}
                : (a_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF);
    assign rep = sz_q == 2'b00 ? {4{d_q[7:0]}} : {2{d_q[15:0]}};
    assign mem_wdata = state != WR ? 32'h0
                     : sz_q == 2'b10 ? d_q
                     : (mem_rdata & ~mask) | (rep & mask);
    assign mem_addr = a_q[ADDR_W-1:2];
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            a_q       <= '0;
            d_q       <= '0;
            sz_q      <= '0;
        end else begin
            state     <= ns;
            req_ready <= ns == IDLE;
            mem_re    <= ns == RD;
            mem_we    <= ns == WR;
            done      <= ns == RESP;
            if (accept) begin
                a_q  <= req_addr;
                d_q  <= req_data;
                sz_q <= req_size;
                err  <= bad;
            end
        end
    end
`ifdef STORE_NARROW_TRUNC_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset)
            trunc_err <= 1'b0;
        else if (accept)
            trunc_err <= !bad && ((req_size == 2'b00 && req_data[31:8] != {24{req_data[7]}})
                              || (req_size == 2'b01 && req_data[31:16] != {16{req_data[15]}}));
    end
`endif
endmodule

// File: tb/tb_store_narrow_rmw.sv
// tb_store_narrow_rmw: randomized store sequences against a word-array reference model
module tb_store_narrow_rmw;
    logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0;
    logic        req_ready, done, err, mem_re, mem_we;
    logic [31:0] req_addr = '0, req_data = '0, mem_rdata = '0, mem_wdata;
    logic [1:0]  req_size = '0;
    logic [29:0] mem_addr;
`ifdef STORE_NARROW_TRUNC_CHECK_EN
    logic        trunc_err;
`endif
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    int tests = 0, fails = 0;

    store_narrow_rmw #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .done(done), .err(err),
`ifdef STORE_NARROW_TRUNC_CHECK_EN
        .trunc_err(trunc_err),
`endif
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[5:0]];
        if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_bad(logic [31:0] addr, logic [1:0] size);
        return size == 3 || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
    endfunction

    function automatic logic [31:0] model(logic [31:0] old, logic [31:0] addr, logic [31:0] data, logic [1:0] size);
        int unsigned pos;
        if (size == 2) return data;
        if (size == 0) begin
            pos = 8 * (addr % 4);
            return old - (((old >> pos) % 256) << pos) + ((data % 256) << pos);
        end
        pos = 16 * ((addr / 2) % 2);
        return old - (((old >> pos) % 65536) << pos) + ((data % 65536) << pos);
    endfunction

    function automatic bit fits(logic [31:0] data, logic [1:0] size);
        int v = int'(data);
        if (size == 0) return v >= -128 && v <= 127;
        if (size == 1) return v >= -32768 && v <= 32767;
        return 1'b1;
    endfunction

    task automatic store(logic [31:0] addr, logic [31:0] data, logic [1:0] size);
        bit bad = is_bad(addr, size);
        int lat = bad ? 1 : (size == 2 ? 2 : 3);
        int first = 0, ndone = 0, nre = 0, nwe = 0, nboth = 0;
        logic [31:0] wd = '0, wa = '0;
        logic e = 1'b0, te = 1'b0;
        logic [31:0] exp_word = model(ref_mem[addr[7:2]], addr, data, size);
        check("ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = addr; req_data = data; req_size = size;
        @(posedge clk);
        #1 req_valid = 1'b0; req_data = $urandom; req_addr = $urandom; req_size = 2'($urandom);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (mem_re && mem_we) nboth++;
            if (mem_re) nre++;
            if (mem_we) begin nwe++; wd = mem_wdata; wa = {2'b0, mem_addr}; end
            if (done) begin
                ndone++;
                if (first == 0) begin
                    first = n; e = err;
`ifdef STORE_NARROW_TRUNC_CHECK_EN
                    te = trunc_err;
`endif
                end
            end
        end
        check("latency", first, lat);
        check("done_count", ndone, 1);
        check("err", {31'b0, e}, {31'b0, bad});
        check("re_count", nre, (!bad && size != 2) ? 1 : 0);
        check("we_count", nwe, bad ? 0 : 1);
        check("re_we_excl", nboth, 0);
        if (!bad) begin
            check("wdata", wd, exp_word);
            check("waddr", wa, addr >> 2);
            ref_mem[addr[7:2]] = exp_word;
        end
`ifdef STORE_NARROW_TRUNC_CHECK_EN
        check("trunc_err", {31'b0, te}, {31'b0, !bad && !fits(data, size)});
`else
        te = 1'b0;
`endif
        check("mem_word", mem[addr[7:2]], ref_mem[addr[7:2]]);
    endtask

    initial begin
        logic [31:0] d;
        int seen_we;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_re", {31'b0, mem_re}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        mem[16] = 32'h1122_3344; ref_mem[16] = mem[16];
        store(32'h42, 32'h0000_00AB, 2'b00);
        check("tp_byte", mem[16], 32'h11AB_3344);
        mem[1] = 32'hDEAD_BEEF; ref_mem[1] = mem[1];
        store(32'h06, 32'h0000_1234, 2'b01);
        check("tp_half", mem[1], 32'h1234_BEEF);
        store(32'h10, 32'hCAFE_F00D, 2'b10);
        check("tp_word", mem[4], 32'hCAFE_F00D);
        store(32'h03, 32'h5555_5555, 2'b01);
        store(32'h20, 32'h6666_6666, 2'b11);
        store(32'h22, 32'h7777_7777, 2'b10);

        // reset while a byte store sits in RD
        req_valid = 1'b1; req_addr = 32'h48; req_data = 32'h99; req_size = 2'b00;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rd_state_re", {31'b0, mem_re}, 32'd1);
        reset = 1'b1;
        seen_we = 0;
        @(negedge clk);
        seen_we += int'(mem_we) + int'(done);
        check("rst_mid_ready", {31'b0, req_ready}, 32'd0);
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            seen_we += int'(mem_we) + int'(done);
        end
        check("rst_mid_no_we_done", seen_we, 0);
        check("rst_mid_ready_after", {31'b0, req_ready}, 32'd1);
        check("rst_mid_mem", mem[18], ref_mem[18]);
        store(32'h4C, 32'h0BAD_CAFE, 2'b10);

`ifdef STORE_NARROW_TRUNC_CHECK_EN
        store(32'h50, 32'hFFFF_FF80, 2'b00);
        store(32'h55, 32'h0000_0180, 2'b00);
        check("trunc_byte_written", {24'b0, mem[21][15:8]}, 32'h80);
`endif

        for (int i = 0; i < 300; i++) begin
            d = $urandom;
            if ($urandom_range(0, 2) == 0) d = {{24{d[7]}}, d[7:0]};
            else if ($urandom_range(0, 2) == 0) d = {{16{d[15]}}, d[15:0]};
            store(32'($urandom_range(0, 255)), d, 2'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/store_narrow_rmw.md
Name: store_narrow_rmw

Overview:
- Store-path counterpart of the load-path sign extender.
- Narrows a 32-bit register value to a byte, halfword or word and writes it into word-addressed data memory.
- Byte and halfword stores use a read-modify-write sequence, so neighbouring bytes in the word are preserved.
- Sits between the datapath store port and the single-port synchronous data memory; it is multi-cycle and handshaked.

Parameters:
- ADDR_W, 32, byte address width; memory word address = addr[ADDR_W-1:2].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  ADDR_W  byte address of the store.
- req_data  in  32  register value to store.
- req_size  in  2  store width: 00 byte, 01 half, 10 word, 11 reserved.
- done  out  1  one-cycle pulse: request finished.
- err  out  1  valid with done: misaligned or reserved size; nothing was written.
- trunc_err  out  1  valid with done; only exists when the optional feature is compiled in.
- mem_addr  out  ADDR_W-2  word address to memory.
- mem_re  out  1  read strobe; mem_rdata is valid on the next cycle.
- mem_rdata  in  32  read data.
- mem_we  out  1  write strobe.
- mem_wdata  out  32  write data.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs are registered and reset to 0, except req_ready, which is 1 in IDLE the cycle after reset deasserts. The state machine resets to IDLE.
- States: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, capture addr, data and size, then decode:
  - size 11, half with addr[0]=1, or word with addr[1:0]!=0 -> RESP with err=1; no memory access.
  - word -> WR.
  - byte or half -> RD.
- RD (1 cycle): mem_re=1, mem_addr=addr[ADDR_W-1:2]. Next state WR.
- WR (1 cycle): mem_we=1, mem_addr unchanged.
  - word: mem_wdata=req_data.
  - byte: mem_wdata=mem_rdata with lane addr[1:0] (bits 8k+7:8k) replaced by req_data[7:0].
  - half: mem_wdata=mem_rdata with bits [15:0] (addr[1]=0) or [31:16] (addr[1]=1) replaced by req_data[15:0].
  - Next state RESP.
- RESP (1 cycle): done=1; err and trunc_err hold their values. Next state IDLE.
- req_ready=0 in RD, WR and RESP. req_valid outside IDLE is ignored; the requester must hold it.
- Latency from the accept edge to done:
  - byte/half: 3 cycles (RD, WR, RESP).
  - word: 2 cycles.
  - error: 1 cycle.
- Back-to-back requests: the next accept is at the earliest the cycle after RESP. mem_re and mem_we are never both high.
- Reset mid-operation: return to IDLE next edge. No mem_we is issued after reset asserts, and no done pulse.
- mem_rdata is sampled only in WR. mem_wdata, mem_re and mem_we are 0 when not in their state.

Optional Feature:
- Macro STORE_NARROW_TRUNC_CHECK_EN.
- When defined:
  - trunc_err port exists.
  - In RESP, trunc_err=1 when a byte store has req_data[31:8] != {24{req_data[7]}}, or a half store has req_data[31:16] != {16{req_data[15]}}. This means the value would not round-trip through sign extension.
  - trunc_err is 0 for word stores and for err responses.
  - The write still occurs; the flag is informational only.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Memory word 0x11223344 at 0x40; byte store addr 0x42, data 0x000000AB -> RD, WR, then done 3 cycles after accept; mem_wdata=0x11AB3344; err=0.
- Memory word 0xDEADBEEF; half store addr 0x06, data 0x00001234 -> mem_wdata=0x1234BEEF, mem_addr=0x1; done 3 cycles after accept.
- Word store addr 0x10, data 0xCAFEF00D -> no mem_re; mem_we with 0xCAFEF00D; done 2 cycles after accept.
- Half store addr 0x03, and separately size=11 -> done 1 cycle after accept with err=1; mem_re=mem_we=0 throughout.
- Byte store in flight; assert reset during RD -> no mem_we, no done; req_ready=1 after release; the following word store completes normally.
- With STORE_NARROW_TRUNC_CHECK_EN defined:
  - byte data 0xFFFFFF80 -> trunc_err=0.
  - byte data 0x00000180 -> trunc_err=1 and the byte 0x80 is still written.
